// File: rtl/branch_update_unit.sv
// In-order branch tracking queue: records predictions, detects mispredicts, squashes
// younger entries, and trains the predictor at commit. Optional stats: NEBULA_BUQ_STATS_EN.
package branch_update_pkg;
   localparam int BP_VADDR_WIDTH = 39;

   typedef struct packed {
      logic [BP_VADDR_WIDTH-1:0] pc;
      logic                      taken;
      logic [BP_VADDR_WIDTH-1:0] target;
      logic                      mispredicted;
      logic                      is_call;
      logic                      is_ret;
   } bp_update_t;
endpackage

// state       | meaning
// ST_EMPTY    | slot free
// ST_PENDING  | allocated, waiting for execute to resolve
// ST_RESOLVED | outcome known, waiting for commit
module branch_update_unit
   import branch_update_pkg::*;
#(
   parameter int VADDR_WIDTH = BP_VADDR_WIDTH,
   parameter int QDEPTH      = 8,
   parameter int TAG_W       = $clog2(QDEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   alloc_valid,
   output logic                   alloc_ready,
   output logic [TAG_W-1:0]       alloc_tag,
   input  logic [VADDR_WIDTH-1:0] alloc_pc,
   input  logic                   alloc_pred_taken,
   input  logic [VADDR_WIDTH-1:0] alloc_pred_target,
   input  logic                   alloc_is_call,
   input  logic                   alloc_is_ret,
   input  logic                   resolve_valid,
   input  logic [TAG_W-1:0]       resolve_tag,
   input  logic                   resolve_taken,
   input  logic [VADDR_WIDTH-1:0] resolve_target,
   input  logic                   commit_valid,
   output logic                   commit_ready,
   output logic                   redirect_valid,
   output logic [VADDR_WIDTH-1:0] redirect_pc,
   output logic                   update_valid,
   output bp_update_t             update
`ifdef NEBULA_BUQ_STATS_EN
   ,
   output logic [31:0]            stat_branches,
   output logic [31:0]            stat_mispredicts
`endif
);

   typedef enum logic [1:0] {ST_EMPTY, ST_PENDING, ST_RESOLVED} ent_state_t;

   ent_state_t             st_q [QDEPTH];
   ent_state_t             st_d [QDEPTH];
   logic [VADDR_WIDTH-1:0] pc_q [QDEPTH];
   logic [VADDR_WIDTH-1:0] pred_target_q [QDEPTH];
   logic [VADDR_WIDTH-1:0] act_target_q [QDEPTH];
   logic                   pred_taken_q [QDEPTH];
   logic                   act_taken_q [QDEPTH];
   logic                   mispred_q [QDEPTH];
   logic                   is_call_q [QDEPTH];
   logic                   is_ret_q [QDEPTH];

   logic [TAG_W:0]   head_q, tail_q, head_d, tail_d, squash_tail;
   logic [TAG_W-1:0] head_idx, tail_idx, res_off, off;
   logic             full, commit_fire, resolve_hit, mispredict, alloc_fire;

   assign head_idx = head_q[TAG_W-1:0];
   assign tail_idx = tail_q[TAG_W-1:0];

   always_comb begin
      full         = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
      alloc_ready  = !full;
      alloc_tag    = tail_idx;
      commit_ready = (st_q[head_idx] == ST_RESOLVED);
      commit_fire  = commit_valid && commit_ready && !flush;
      resolve_hit  = resolve_valid && (st_q[resolve_tag] == ST_PENDING) && !flush;
      mispredict   = resolve_hit &&
                     ((resolve_taken != pred_taken_q[resolve_tag]) ||
                      (resolve_taken && (resolve_target != pred_target_q[resolve_tag])));
      alloc_fire   = alloc_valid && !full && !flush && !mispredict;
      // age of the resolving entry relative to head rebuilds the wrap bit of the new tail
      res_off      = resolve_tag - head_idx;
      squash_tail  = head_q + {1'b0, res_off} + (TAG_W+1)'(1);
   end

   always_comb begin
      off = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         st_d[i] = st_q[i];
         off     = TAG_W'(i) - head_idx;
         if (flush) begin
            st_d[i] = ST_EMPTY;
         end else begin
            if (alloc_fire && (TAG_W'(i) == tail_idx))    st_d[i] = ST_PENDING;
            if (resolve_hit && (TAG_W'(i) == resolve_tag)) st_d[i] = ST_RESOLVED;
            if (commit_fire && (TAG_W'(i) == head_idx))   st_d[i] = ST_EMPTY;
            if (mispredict && (off > res_off))            st_d[i] = ST_EMPTY;
         end
      end
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         tail_d = head_q;
      end else begin
         if (commit_fire) head_d = head_q + (TAG_W+1)'(1);
         if (mispredict)      tail_d = squash_tail;
         else if (alloc_fire) tail_d = tail_q + (TAG_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            st_q[i]          <= ST_EMPTY;
            pc_q[i]          <= '0;
            pred_target_q[i] <= '0;
            act_target_q[i]  <= '0;
            pred_taken_q[i]  <= 1'b0;
            act_taken_q[i]   <= 1'b0;
            mispred_q[i]     <= 1'b0;
            is_call_q[i]     <= 1'b0;
            is_ret_q[i]      <= 1'b0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         for (int i = 0; i < QDEPTH; i++) st_q[i] <= st_d[i];
         if (alloc_fire) begin
            pc_q[tail_idx]          <= alloc_pc;
            pred_taken_q[tail_idx]  <= alloc_pred_taken;
            pred_target_q[tail_idx] <= alloc_pred_target;
            is_call_q[tail_idx]     <= alloc_is_call;
            is_ret_q[tail_idx]      <= alloc_is_ret;
         end
         if (resolve_hit) begin
            act_taken_q[resolve_tag]  <= resolve_taken;
            act_target_q[resolve_tag] <= resolve_target;
            mispred_q[resolve_tag]    <= mispredict;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         update_valid   <= 1'b0;
         update         <= '0;
      end else begin
         redirect_valid <= mispredict;
         update_valid   <= commit_fire;
         if (mispredict)
            redirect_pc <= resolve_taken ? resolve_target
                                         : pc_q[resolve_tag] + VADDR_WIDTH'(4);
         if (commit_fire) begin
            update.pc           <= pc_q[head_idx];
            update.taken        <= act_taken_q[head_idx];
            update.target       <= act_target_q[head_idx];
            update.mispredicted <= mispred_q[head_idx];
            update.is_call      <= is_call_q[head_idx];
            update.is_ret       <= is_ret_q[head_idx];
         end
      end
   end

`ifdef NEBULA_BUQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (update_valid) begin
         if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
         if (update.mispredicted && (stat_mispredicts != 32'hFFFF_FFFF))
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// Bench for branch_update_unit: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_branch_update_unit;
   import branch_update_pkg::*;

   localparam int VW = 39;
   localparam int QD = 8;
   localparam int TW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush, alloc_valid, alloc_pred_taken, alloc_is_call, alloc_is_ret;
   logic          resolve_valid, resolve_taken, commit_valid;
   logic [VW-1:0] alloc_pc, alloc_pred_target, resolve_target;
   logic [TW-1:0] resolve_tag;
   logic          alloc_ready, commit_ready, redirect_valid, update_valid;
   logic [TW-1:0] alloc_tag;
   logic [VW-1:0] redirect_pc;
   bp_update_t    update;
`ifdef NEBULA_BUQ_STATS_EN
   logic [31:0]   stat_branches, stat_mispredicts;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_update_unit #(.VADDR_WIDTH(VW), .QDEPTH(QD)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
      .alloc_pred_target(alloc_pred_target), .alloc_is_call(alloc_is_call),
      .alloc_is_ret(alloc_is_ret), .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
      .resolve_taken(resolve_taken), .resolve_target(resolve_target),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .update_valid(update_valid), .update(update)
`ifdef NEBULA_BUQ_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   // reference model: list of in-flight branches, oldest first
   typedef struct {
      int            tag;
      logic [VW-1:0] pc, pred_tgt, tgt;
      logic          pt, tk, call, ret, res, mis;
   } ment_t;

   ment_t         q[$];
   int            m_head, m_tail;
   logic          exp_rv, exp_uv;
   logic [VW-1:0] exp_rpc;
   bp_update_t    exp_upd;

   task automatic model_reset();
      q.delete();
      m_head = 0; m_tail = 0;
      exp_rv = 0; exp_uv = 0; exp_rpc = '0; exp_upd = '0;
   endtask

   task automatic idle();
      flush = 0; alloc_valid = 0; alloc_pc = '0; alloc_pred_taken = 0; alloc_pred_target = '0;
      alloc_is_call = 0; alloc_is_ret = 0; resolve_valid = 0; resolve_tag = '0;
      resolve_taken = 0; resolve_target = '0; commit_valid = 0;
   endtask

   task automatic set_alloc(input logic [VW-1:0] pc, input logic pt, input logic [VW-1:0] tgt);
      alloc_valid = 1; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_target = tgt;
   endtask

   task automatic set_resolve(input logic [TW-1:0] tag, input logic tk, input logic [VW-1:0] tgt);
      resolve_valid = 1; resolve_tag = tag; resolve_taken = tk; resolve_target = tgt;
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   // advance one clock and apply the same inputs to the model
   task automatic tick();
      bit    do_commit, do_alloc, mis;
      int    idx;
      ment_t e;
      @(posedge clk);
      exp_rv = 0; exp_uv = 0;
      if (flush) begin
         q.delete();
         m_tail = m_head;
      end else begin
         do_commit = commit_valid && q.size() > 0 && q[0].res;
         do_alloc  = alloc_valid && q.size() < QD;
         idx = -1;
         foreach (q[k]) if (q[k].tag == int'(resolve_tag) && !q[k].res) idx = k;
         if (resolve_valid && idx >= 0) begin
            mis = (resolve_taken != q[idx].pt) || (resolve_taken && resolve_target != q[idx].pred_tgt);
            q[idx].res = 1; q[idx].tk = resolve_taken; q[idx].tgt = resolve_target; q[idx].mis = mis;
            if (mis) begin
               exp_rv  = 1;
               exp_rpc = resolve_taken ? resolve_target : q[idx].pc + 4;
               while (q.size() > idx + 1) void'(q.pop_back());
               m_tail   = (int'(resolve_tag) + 1) % QD;
               do_alloc = 0;
            end
         end
         if (do_commit) begin
            e = q.pop_front();
            exp_uv = 1;
            exp_upd.pc = e.pc; exp_upd.taken = e.tk; exp_upd.target = e.tgt;
            exp_upd.mispredicted = e.mis; exp_upd.is_call = e.call; exp_upd.is_ret = e.ret;
            m_head = (m_head + 1) % QD;
         end
         if (do_alloc) begin
            e.tag = m_tail; e.pc = alloc_pc; e.pred_tgt = alloc_pred_target; e.pt = alloc_pred_taken;
            e.call = alloc_is_call; e.ret = alloc_is_ret; e.res = 0; e.tk = 0; e.tgt = '0; e.mis = 0;
            q.push_back(e);
            m_tail = (m_tail + 1) % QD;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid got=%0b exp=0", redirect_valid); end
      checks++; if (redirect_pc !== '0) begin errors++; $display("FAIL rst_redirect_pc got=%h exp=0", redirect_pc); end
      checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL rst_update_valid got=%0b exp=0", update_valid); end
      checks++; if (update !== '0) begin errors++; $display("FAIL rst_update got=%h exp=0", update); end
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_alloc_ready got=%0b exp=1", alloc_ready); end
      checks++; if (commit_ready !== 1'b0) begin errors++; $display("FAIL rst_commit_ready got=%0b exp=0", commit_ready); end
      checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL rst_alloc_tag got=%0d exp=0", alloc_tag); end
   endtask

   task automatic test_basic();
      apply_reset();
      set_alloc(39'h1000, 1, 39'h2000); tick(); idle();
      set_resolve(0, 1, 39'h2000); tick(); idle();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL basic_no_redirect got=%0b exp=0", redirect_valid); end
      commit_valid = 1; tick(); idle();
      checks++; if (update_valid !== 1'b1) begin errors++; $display("FAIL basic_update_valid got=%0b exp=1", update_valid); end
      checks++; if (update.pc !== 39'h1000 || update.taken !== 1'b1 || update.mispredicted !== 1'b0)
         begin errors++; $display("FAIL basic_update got pc=%h tk=%0b mis=%0b exp pc=1000 tk=1 mis=0", update.pc, update.taken, update.mispredicted); end
      tick();
      checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL basic_update_pulse got=%0b exp=0", update_valid); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL basic_no_redirect_late got=%0b exp=0", redirect_valid); end
   endtask

   task automatic test_mispredict();
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         set_alloc(39'h1000 + VW'(k * 16), 1, 39'h2000); tick();
      end
      idle();
      set_resolve(0, 0, 39'h0);
      set_alloc(39'h5000, 0, 39'h0);
      tick(); idle();
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL mis_redirect_valid got=%0b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 39'h1004) begin errors++; $display("FAIL mis_redirect_pc got=%h exp=1004", redirect_pc); end
      checks++; if (alloc_tag !== 3'd1) begin errors++; $display("FAIL mis_alloc_tag got=%0d exp=1", alloc_tag); end
      tick();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mis_redirect_pulse got=%0b exp=0", redirect_valid); end
      set_resolve(1, 0, 39'h0); tick(); idle();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mis_squashed_resolve got=%0b exp=0", redirect_valid); end
      commit_valid = 1; tick(); idle();
      checks++; if (update_valid !== 1'b1 || update.mispredicted !== 1'b1 || update.pc !== 39'h1000 || update.taken !== 1'b0)
         begin errors++; $display("FAIL mis_update got v=%0b mis=%0b pc=%h tk=%0b exp v=1 mis=1 pc=1000 tk=0", update_valid, update.mispredicted, update.pc, update.taken); end
      checks++; if (alloc_tag !== 3'd1 || commit_ready !== 1'b0)
         begin errors++; $display("FAIL mis_empty got tag=%0d cr=%0b exp tag=1 cr=0", alloc_tag, commit_ready); end
   endtask

   task automatic test_full();
      apply_reset();
      for (int k = 0; k < QD; k++) begin
         set_alloc(VW'(k * 256), 0, '0); tick();
      end
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got=%0b exp=0", alloc_ready); end
      set_alloc(39'h7777, 0, '0); tick(); idle();
      checks++; if (alloc_tag !== 3'd0 || alloc_ready !== 1'b0)
         begin errors++; $display("FAIL full_ninth got tag=%0d ar=%0b exp tag=0 ar=0", alloc_tag, alloc_ready); end
      set_resolve(0, 0, '0); tick(); idle();
      commit_valid = 1; set_alloc(39'h8888, 0, '0); tick(); idle();
      checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0)
         begin errors++; $display("FAIL full_after_commit got ar=%0b tag=%0d exp ar=1 tag=0", alloc_ready, alloc_tag); end
      checks++; if (update_valid !== 1'b1 || update.pc !== 39'h0)
         begin errors++; $display("FAIL full_update got v=%0b pc=%h exp v=1 pc=0", update_valid, update.pc); end
      set_alloc(39'h9000, 0, '0); tick(); idle();
      checks++; if (alloc_tag !== 3'd1 || alloc_ready !== 1'b0)
         begin errors++; $display("FAIL full_wrap got tag=%0d ar=%0b exp tag=1 ar=0", alloc_tag, alloc_ready); end
   endtask

   task automatic test_order();
      logic [VW-1:0] pcs [3];
      pcs[0] = 39'h40; pcs[1] = 39'h80; pcs[2] = 39'hC0;
      apply_reset();
      for (int k = 0; k < 3; k++) begin set_alloc(pcs[k], 1, 39'h400); tick(); end
      idle();
      for (int k = 2; k >= 0; k--) begin
         set_resolve(TW'(k), 1, 39'h400); commit_valid = 1; tick(); idle();
         checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL order_early_update k=%0d got=%0b exp=0", k, update_valid); end
         checks++; if (commit_ready !== (k == 0)) begin errors++; $display("FAIL order_commit_ready k=%0d got=%0b exp=%0b", k, commit_ready, k == 0); end
      end
      for (int k = 0; k < 3; k++) begin
         commit_valid = 1; tick(); idle();
         checks++; if (update_valid !== 1'b1 || update.pc !== pcs[k])
            begin errors++; $display("FAIL order_update k=%0d got v=%0b pc=%h exp v=1 pc=%h", k, update_valid, update.pc, pcs[k]); end
      end
      checks++; if (commit_ready !== 1'b0) begin errors++; $display("FAIL order_drained got=%0b exp=0", commit_ready); end
   endtask

   task automatic test_flush();
      apply_reset();
      for (int k = 0; k < 4; k++) begin set_alloc(VW'(k * 8), 0, '0); tick(); end
      idle();
      set_resolve(0, 0, '0); tick(); idle();
      commit_valid = 1; flush = 1; set_resolve(1, 1, 39'h55); tick(); idle();
      checks++; if (update_valid !== 1'b0 || redirect_valid !== 1'b0)
         begin errors++; $display("FAIL flush_outputs got uv=%0b rv=%0b exp 0 0", update_valid, redirect_valid); end
      checks++; if (commit_ready !== 1'b0 || alloc_tag !== 3'd0 || alloc_ready !== 1'b1)
         begin errors++; $display("FAIL flush_empty got cr=%0b tag=%0d ar=%0b exp cr=0 tag=0 ar=1", commit_ready, alloc_tag, alloc_ready); end
      tick();
      checks++; if (update_valid !== 1'b0) begin errors++; $display("FAIL flush_no_late_update got=%0b exp=0", update_valid); end
   endtask

   task automatic test_random();
      int            k;
      logic          bpt;
      logic [VW-1:0] btgt;
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         idle();
         if ($urandom_range(0, 99) < 55) begin
            set_alloc(VW'($urandom) << 2, 1'($urandom), VW'($urandom_range(0, 15)) << 4);
            alloc_is_call = 1'($urandom); alloc_is_ret = 1'($urandom);
         end
         if ($urandom_range(0, 99) < 50) begin
            if (q.size() > 0 && $urandom_range(0, 99) < 85) begin
               k = $urandom_range(0, q.size() - 1);
               resolve_tag = TW'(q[k].tag); bpt = q[k].pt; btgt = q[k].pred_tgt;
            end else begin
               resolve_tag = TW'($urandom); bpt = 1'($urandom); btgt = VW'($urandom);
            end
            resolve_valid  = 1;
            resolve_taken  = ($urandom_range(0, 4) != 0) ? bpt : ~bpt;
            resolve_target = ($urandom_range(0, 4) != 0) ? btgt : VW'($urandom_range(0, 15)) << 4;
         end
         commit_valid = ($urandom_range(0, 99) < 50);
         flush        = ($urandom_range(0, 99) < 2);
         tick();
         checks++; if (redirect_valid !== exp_rv) begin errors++; $display("FAIL rnd_redirect_valid c=%0d got=%0b exp=%0b", c, redirect_valid, exp_rv); end
         if (exp_rv) begin
            checks++; if (redirect_pc !== exp_rpc) begin errors++; $display("FAIL rnd_redirect_pc c=%0d got=%h exp=%h", c, redirect_pc, exp_rpc); end
         end
         checks++; if (update_valid !== exp_uv) begin errors++; $display("FAIL rnd_update_valid c=%0d got=%0b exp=%0b", c, update_valid, exp_uv); end
         if (exp_uv) begin
            checks++; if (update !== exp_upd) begin errors++; $display("FAIL rnd_update c=%0d got=%h exp=%h", c, update, exp_upd); end
         end
         checks++; if (alloc_ready !== (q.size() < QD)) begin errors++; $display("FAIL rnd_alloc_ready c=%0d got=%0b exp=%0b", c, alloc_ready, q.size() < QD); end
         checks++; if (alloc_tag !== TW'(m_tail)) begin errors++; $display("FAIL rnd_alloc_tag c=%0d got=%0d exp=%0d", c, alloc_tag, m_tail); end
         checks++; if (commit_ready !== (q.size() > 0 && q[0].res)) begin errors++; $display("FAIL rnd_commit_ready c=%0d got=%0b exp=%0b", c, commit_ready, q.size() > 0 && q[0].res); end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_alloc(39'h300, 1, 39'h600); tick();
      set_alloc(39'h310, 1, 39'h600); tick(); idle();
      set_resolve(0, 0, '0); tick(); idle();
      #2 rst_n = 0;
      #1;
      checks++; if (redirect_valid !== 1'b0 || redirect_pc !== '0)
         begin errors++; $display("FAIL midrst_redirect got v=%0b pc=%h exp v=0 pc=0", redirect_valid, redirect_pc); end
      checks++; if (alloc_tag !== 3'd0 || alloc_ready !== 1'b1 || commit_ready !== 1'b0)
         begin errors++; $display("FAIL midrst_queue got tag=%0d ar=%0b cr=%0b exp 0 1 0", alloc_tag, alloc_ready, commit_ready); end
      @(posedge clk); #1 rst_n = 1;
      model_reset();
   endtask

`ifdef NEBULA_BUQ_STATS_EN
   task automatic test_stats();
      apply_reset();
      for (int k = 0; k < 3; k++) begin set_alloc(VW'(k * 4), 1, 39'h2000); tick(); end
      idle();
      set_resolve(0, 1, 39'h2000); tick();
      set_resolve(1, 1, 39'h2000); tick();
      set_resolve(2, 0, '0); tick(); idle();
      for (int k = 0; k < 3; k++) begin commit_valid = 1; tick(); end
      idle(); tick(); tick();
      checks++; if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1)
         begin errors++; $display("FAIL stats_count got br=%0d mis=%0d exp br=3 mis=1", stat_branches, stat_mispredicts); end
      flush = 1; tick(); idle(); tick();
      checks++; if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1)
         begin errors++; $display("FAIL stats_after_flush got br=%0d mis=%0d exp br=3 mis=1", stat_branches, stat_mispredicts); end
   endtask
`endif

   initial begin
      idle();
      model_reset();
      test_reset();
      test_basic();
      test_mispredict();
      test_full();
      test_order();
      test_flush();
      test_random();
      test_reset_mid();
`ifdef NEBULA_BUQ_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_update_unit.md
Name: branch_update_unit

Overview:
In-order tracking queue between fetch, execute and commit for every predicted control-flow instruction. It records each prediction the branch predictor makes, captures the resolved outcome from execute, and detects mispredictions. It raises a front-end redirect and squashes younger entries on a mispredict. At commit it drives the predictor's update_valid / update (bp_update_t) port in program order, so predictor training never sees wrong-path branches.

Parameters:
VADDR_WIDTH, 39, virtual address width.
QDEPTH, 8, queue entries; power of two, at least 2.
TAG_W, $clog2(QDEPTH), entry tag width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (exception/fence); clears queue
alloc_valid  in  1  fetch allocates an entry for a predicted control-flow instruction
alloc_ready  out  1  queue not full
alloc_tag  out  TAG_W  tag given to the allocating instruction (current tail index)
alloc_pc  in  VADDR_WIDTH  instruction PC
alloc_pred_taken  in  1  predicted direction
alloc_pred_target  in  VADDR_WIDTH  predicted target
alloc_is_call  in  1  call
alloc_is_ret  in  1  return
resolve_valid  in  1  execute has resolved a branch
resolve_tag  in  TAG_W  tag of the resolved entry
resolve_taken  in  1  actual direction
resolve_target  in  VADDR_WIDTH  actual target
commit_valid  in  1  commit retires the oldest branch
commit_ready  out  1  head entry is RESOLVED
redirect_valid  out  1  one-cycle front-end redirect pulse
redirect_pc  out  VADDR_WIDTH  correct fetch PC
update_valid  out  1  predictor training strobe
update  out  bp_update_t  pc, taken, target, mispredicted, is_call, is_ret

Behaviour:
- Reset: clk and rst_n as stated; reset is asynchronous, active-low. All entries EMPTY; head=tail=0 with wrap bit 0. redirect_valid=0, redirect_pc=0, update_valid=0, update='0. alloc_ready=1, commit_ready=0.
- Entry states: EMPTY -> PENDING (alloc) -> RESOLVED (resolve) -> EMPTY (commit, squash or flush).
- Pointers are TAG_W+1 bits. full = indices equal and wrap bits differ. empty = pointers equal.
- alloc_ready = !full (combinational). alloc_tag = tail[TAG_W-1:0].
- Allocation: alloc_valid && alloc_ready writes the entry as PENDING and increments tail.
- Resolve applies only if the target entry is PENDING; otherwise it is ignored. It stores taken, target and the mispredicted bit.
- mispredicted = (resolve_taken != pred_taken) || (resolve_taken && resolve_target != pred_target).
- On mispredict, all entries younger than resolve_tag become EMPTY and tail = resolve_tag+1 (wrap bit recomputed). An alloc in the same cycle is discarded.
- Redirect is registered: next cycle redirect_valid=1 and redirect_pc = resolve_taken ? resolve_target : pc+4. The pulse lasts exactly one cycle. A second mispredict while the pulse is high overrides it on the next cycle.
- commit_ready = head entry RESOLVED. commit_valid && !commit_ready is ignored.
- Commit handshake (commit_valid && commit_ready) frees the head and increments it. Next cycle update_valid=1 for one cycle with update filled from the entry. Latency from handshake to update_valid is 1 cycle.
- Full queue with simultaneous commit: no alloc is accepted that cycle (alloc_ready reflects the pre-commit count).
- Resolve and commit are both allowed on the same cycle, on different entries.
- A mispredict on the head entry still commits normally later. It produces an update with mispredicted=1.
- flush has highest priority. All entries become EMPTY, head=tail (wrap bits equal), and pending redirect_valid and update_valid are cleared next cycle. Any commit or resolve in that cycle is dropped.
- Reset mid-operation returns every state element to its reset value immediately.

Optional Feature:
NEBULA_BUQ_STATS_EN
- When defined: adds outputs stat_branches and stat_mispredicts (32 bits each, saturating at 0xFFFFFFFF). Each counts committed entries and committed mispredicted entries, updated with update_valid. Both reset to 0 and are unaffected by flush.
- When undefined: these ports and counters do not exist, and the block has no other difference.

Test Plan:
- Alloc pc=0x1000, pred_taken=1, target=0x2000. Resolve tag 0, taken=1, target=0x2000. Commit. Required: update_valid pulse one cycle after commit, pc=0x1000, taken=1, mispredicted=0, redirect_valid never set.
- Alloc tags 0,1,2. Resolve tag 0 with taken=0 against pred_taken=1, pc=0x1000. Required: next cycle redirect_valid=1, redirect_pc=0x1004. Tags 1 and 2 squashed, next alloc_tag=1, later update mispredicted=1.
- Alloc 8 entries. Required: alloc_ready=0, and a 9th alloc_valid is not accepted. Resolve and commit the head. Required: alloc_ready=1 the cycle after, tail wraps to index 0 cleanly.
- Resolve tag 2 before tag 0, then assert commit_valid. Required: commit_ready=0 and no update until tag 0 resolves. Updates then appear in order 0,1,2.
- Fill 4 entries, then assert flush in the same cycle as a commit handshake. Required: no update_valid, and queue empty (alloc_tag equals head index, commit_ready=0).
- Stats build: 3 commits with 1 mispredict. Required: stat_branches=3, stat_mispredicts=1, both held after flush.
